// File: rtl/ofm_drain_pkg.sv
// Shared definitions for the OFM drain: state encoding, default geometry and the
// pixel saturation rule (also usable by the PE datapath).
package ofm_drain_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam int         P_DEF     = 4;
  localparam int         DEPTH_DEF = 16;
  localparam int         IW_DEF    = 16;
  localparam int         OW_DEF    = 8;
  localparam int         AW_DEF    = 9;
  localparam logic [8:0] BASE_DEF  = 9'd256;

  // relu=1 clamps to [0, 2^ow-1]; relu=0 clamps to [-2^(ow-1), 2^(ow-1)-1].
  function automatic logic [31:0] sat_px(input logic signed [31:0] x, input logic relu,
                                         input int ow);
    logic signed [31:0] hi, lo;
    hi = relu ? (32'sd1 <<< ow) - 32'sd1 : (32'sd1 <<< (ow - 1)) - 32'sd1;
    lo = relu ? 32'sd0 : -(32'sd1 <<< (ow - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/ofm_drain_if.sv
// PE read port plus memory write port of the OFM drain.
interface ofm_drain_if #(
  parameter int P     = 4,
  parameter int DEPTH = 16,
  parameter int IW    = 16,
  parameter int OW    = 8,
  parameter int AW    = 9
);
  logic [P-1:0]              pe_rd_en;
  logic [$clog2(DEPTH)-1:0]  pe_rd_addr;
  logic [P*IW-1:0]           pe_rdata;
  logic                      mem_we;
  logic [AW-1:0]             mem_addr;
  logic [OW-1:0]             mem_wdata;
  logic                      mem_ready;

  modport master (output pe_rd_en, pe_rd_addr, mem_we, mem_addr, mem_wdata,
                  input  pe_rdata, mem_ready);
  modport slave  (input  pe_rd_en, pe_rd_addr, mem_we, mem_addr, mem_wdata,
                  output pe_rdata, mem_ready);
endinterface

// File: rtl/ofm_sat.sv
// Combinational MAC-width to pixel-width converter (ReLU/unsigned or signed saturation).
module ofm_sat
  import ofm_drain_pkg::*;
#(
  parameter int IW = IW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic [IW-1:0] din,
  input  logic          relu_en,
  output logic [OW-1:0] dout
);
  assign dout = OW'(sat_px(32'($signed(din)), relu_en, OW));
endmodule

// File: rtl/ofm_drain.sv
// Drains P PE output-feature-map buffers word by word into consecutive memory
// addresses starting at BASE, converting each word to pixel width.
module ofm_drain
  import ofm_drain_pkg::*;
#(
  parameter int            P     = P_DEF,
  parameter int            DEPTH = DEPTH_DEF,
  parameter int            IW    = IW_DEF,
  parameter int            OW    = OW_DEF,
  parameter int            AW    = AW_DEF,
  parameter logic [AW-1:0] BASE  = AW'(BASE_DEF)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        relu_en,
  output logic        busy,
  output logic        done,
  ofm_drain_if.master bus
);
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int DW = $clog2(DEPTH);

  logic [2:0]    state;
  logic [PW-1:0] pe_idx;
  logic [DW-1:0] word_idx;
  logic          relu_q;
  logic [OW-1:0] wdata_q;
  logic [IW-1:0] rd_word;
  logic [OW-1:0] sat_out;
  logic          last_word, last_pe;

  assign rd_word   = bus.pe_rdata[pe_idx*IW +: IW];
  assign last_word = (word_idx == DW'(DEPTH - 1));
  assign last_pe   = (pe_idx == PW'(P - 1));

  ofm_sat #(.IW(IW), .OW(OW)) u_sat (
    .din     (rd_word),
    .relu_en (relu_q),
    .dout    (sat_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pe_idx   <= '0;
      word_idx <= '0;
      relu_q   <= 1'b0;
      wdata_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          pe_idx   <= '0;
          word_idx <= '0;
          relu_q   <= relu_en;
          state    <= ST_RD;
        end
        ST_RD:   state <= ST_WAIT;
        ST_WAIT: begin
          wdata_q <= sat_out;
          state   <= ST_WR;
        end
        ST_WR: if (bus.mem_ready) begin
          if (last_word && last_pe) begin
            state <= ST_DONE;
          end else begin
            word_idx <= last_word ? '0 : word_idx + 1'b1;
            if (last_word) pe_idx <= pe_idx + 1'b1;
            state <= ST_RD;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode from state only, so an async reset clears them at once.
  always_comb begin
    bus.pe_rd_en   = '0;
    bus.pe_rd_addr = '0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    if (state == ST_RD) begin
      bus.pe_rd_en   = P'(1) << pe_idx;
      bus.pe_rd_addr = word_idx;
    end
    if (state == ST_WR) begin
      bus.mem_we    = 1'b1;
      bus.mem_addr  = AW'(32'(BASE) + 32'(pe_idx) * 32'(DEPTH) + 32'(word_idx));
      bus.mem_wdata = wdata_q;
    end
  end

  assign busy = (state == ST_RD) || (state == ST_WAIT) || (state == ST_WR);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_ofm_drain.sv
// Randomized self-checking bench for ofm_drain against a write-sequence reference model.
module tb_ofm_drain;
  localparam int P = 4, DEPTH = 16, IW = 16, OW = 8, AW = 9;
  localparam int N = P * DEPTH;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, relu_en = 1'b0;
  logic busy, done;

  ofm_drain_if #(.P(P), .DEPTH(DEPTH), .IW(IW), .OW(OW), .AW(AW)) bus ();

  ofm_drain #(.P(P), .DEPTH(DEPTH), .IW(IW), .OW(OW), .AW(AW), .BASE(9'd256)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .relu_en (relu_en),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] pe_mem [P][DEPTH];
  logic [7:0]  got [N];
  int n_chk = 0, n_fail = 0;

  // PE buffers: registered read, data valid the cycle after the strobe.
  always @(posedge clk)
    for (int i = 0; i < P; i++)
      if (bus.pe_rd_en[i]) bus.pe_rdata[i*IW +: IW] <= pe_mem[i][bus.pe_rd_addr];

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.pe_rd_en, bus.pe_rd_addr, bus.mem_we, bus.mem_addr, bus.mem_wdata, busy, done});
  endfunction

  function automatic logic [7:0] ref_px(input logic [15:0] w, input bit relu);
    int v;
    v = int'($signed(w));
    if (relu) v = (v < 0) ? 0 : ((v > 255) ? 255 : v);
    else      v = (v < -128) ? -128 : ((v > 127) ? 127 : v);
    return v[7:0];
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < P; i++)
      for (int a = 0; a < DEPTH; a++) pe_mem[i][a] = 16'(i * 16 + a);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < P; i++)
      for (int a = 0; a < DEPTH; a++) pe_mem[i][a] = 16'($urandom);
  endtask

  // One drain; cycle k is observed at the negedge following the k-th edge after start.
  task automatic drain(input bit relu, input int stall_at, input int stall_len,
                       input bit rnd, input bit noise, input int abort_at);
    int n_wr = 0, st = 0, stall_tot = 0, done_cnt = 0, done_cyc = -1;
    int busy_cnt = 0, busy_first = -1, busy_last = -1, tail = -1;
    bit rdy;
    @(negedge clk);
    relu_en = relu;
    start   = 1'b1;
    bus.mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    for (int k = 1; k < 3000; k++) begin
      start = 1'b0;
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = k;
        busy_last = k;
      end
      if (done) begin
        done_cnt++;
        done_cyc = k;
        if (tail < 0) tail = k;
      end
      if (bus.pe_rd_en != '0 && n_wr < N) begin
        chk("rd_en", 32'(bus.pe_rd_en), 32'(1 << (n_wr / DEPTH)));
        chk("rd_addr", 32'(bus.pe_rd_addr), 32'(n_wr % DEPTH));
      end
      rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (bus.mem_we) begin
        if (n_wr == abort_at) begin
          rst_n = 1'b0;
          #1 chk("abort_out", outs(), 32'd0);
          repeat (3) begin
            @(negedge clk);
            chk("abort_quiet", outs(), 32'd0);
          end
          rst_n = 1'b1;
          return;
        end
        if (n_wr < N) begin
          chk("wr_addr", 32'(bus.mem_addr), 32'((256 + n_wr) % 512));
          chk("wr_data", 32'(bus.mem_wdata),
              32'(ref_px(pe_mem[n_wr / DEPTH][n_wr % DEPTH], relu)));
        end
        if (n_wr == stall_at && st < stall_len) begin
          rdy = 1'b0;
          st++;
        end
        if (!rdy) stall_tot++;
        else begin
          if (n_wr < N) got[n_wr] = bus.mem_wdata;
          n_wr++;
        end
      end
      bus.mem_ready = rdy;
      if (noise && busy) begin
        start   = 1'($urandom_range(0, 1));
        relu_en = 1'($urandom_range(0, 1));
      end
      if (noise && done) start = 1'b1;
      if (tail >= 0 && k >= tail + 4) break;
      @(negedge clk);
    end
    start = 1'b0;
    chk("n_wr", 32'(n_wr), 32'(N));
    chk("done_cnt", 32'(done_cnt), 32'd1);
    chk("done_cyc", 32'(done_cyc), 32'(3 * N + 1 + stall_tot));
    chk("busy_cnt", 32'(busy_cnt), 32'(3 * N + stall_tot));
    chk("busy_first", 32'(busy_first), 32'd1);
    chk("busy_last", 32'(busy_last), 32'(done_cyc - 1));
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      relu_en = 1'($urandom_range(0, 1));
      bus.mem_ready = 1'($urandom_range(0, 1));
      chk("rst_out", outs(), 32'd0);
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst", outs(), 32'd0);
    end

    // Full drain of the ramp pattern: addresses 256..319, data 0..63.
    fill_ramp();
    drain(1'b1, -1, 0, 1'b0, 1'b0, -1);
    chk("ramp_d0", 32'(got[0]), 32'd0);
    chk("ramp_d63", 32'(got[63]), 32'd63);

    // Conversion corner values in both modes.
    fill_rand();
    pe_mem[0][0] = 16'h0123;
    pe_mem[0][1] = 16'hFF80;
    pe_mem[0][2] = 16'h0050;
    pe_mem[0][3] = 16'hFF38;
    drain(1'b1, -1, 0, 1'b0, 1'b0, -1);
    chk("cv_r_0123", 32'(got[0]), 32'hFF);
    chk("cv_r_ff80", 32'(got[1]), 32'h00);
    chk("cv_r_0050", 32'(got[2]), 32'h50);
    chk("cv_r_ff38", 32'(got[3]), 32'h00);
    drain(1'b0, -1, 0, 1'b0, 1'b0, -1);
    chk("cv_s_0123", 32'(got[0]), 32'h7F);
    chk("cv_s_ff80", 32'(got[1]), 32'h80);
    chk("cv_s_0050", 32'(got[2]), 32'h50);
    chk("cv_s_ff38", 32'(got[3]), 32'h80);

    // Backpressure on the third write (address 258).
    fill_ramp();
    drain(1'b1, 2, 5, 1'b0, 1'b0, -1);

    // Reset during write of word 10, then a clean drain from 256.
    fill_rand();
    drain(1'b1, -1, 0, 1'b0, 1'b0, 10);
    drain(1'b0, -1, 0, 1'b0, 1'b0, -1);

    // start/relu_en noise while busy and during DONE.
    fill_rand();
    drain(1'b1, -1, 0, 1'b1, 1'b1, -1);

    repeat (3) begin
      fill_rand();
      drain(1'($urandom_range(0, 1)), -1, 0, 1'b1, 1'b0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
